// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch front end. It reads 16-bit instruction words from main
// memory and queues them, each with its byte address, in a 4-entry buffer.
// The control unit takes entries from the head of the buffer. A redirect
// (jump/skip) flushes the buffer and restarts fetch at a new address. A halt
// flushes the buffer and stops fetch until the next reset.
//
// Ports
//   clk           in   single clock; all state updates on posedge
//   reset         in   synchronous, active-high reset
//   mem_rd_en     out  main-memory read strobe
//   mem_addr      out  byte address of the read (always even)
//   mem_rdata     in   little-endian word, valid 1 cycle after mem_rd_en
//   instr         out  instruction at the buffer head
//   instr_pc      out  byte address of instr
//   instr_valid   out  instr / instr_pc are valid
//   instr_ready   in   control accepts the head entry
//   redirect      in   jump/skip taken, one-cycle pulse
//   redirect_addr in   new fetch byte address
//   halt          in   halt opcode executed
//   halted        out  fetch stopped
//   buf_count     out  buffer occupancy, 0..4
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        halt,
    output logic        halted,
    output logic [2:0]  buf_count
);

    localparam logic STATE_RUN    = 1'b0;
    localparam logic STATE_HALTED = 1'b1;

    logic        state;
    logic [15:0] fetch_pc;
    logic        rd_pending;
    logic [15:0] rd_addr;
    logic [15:0] buf_data [BUF_DEPTH];
    logic [15:0] buf_pc   [BUF_DEPTH];
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [2:0]  count;
    logic        running;
    logic        flush;
    logic        push;
    logic        pop;
    logic        unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_addr[0];

    assign running = (state == STATE_RUN);
    assign flush   = running && (redirect || halt);

    // rd_pending is the one read whose data is on mem_rdata this cycle. It is
    // counted against the buffer space, but a pop in the same cycle is not
    // counted as free space. This keeps the overflow check registered-only.
    assign mem_rd_en = !reset && running && !redirect && !halt &&
                       ((count + {2'b00, rd_pending}) < 3'(BUF_DEPTH));
    assign mem_addr  = reset ? RESET_PC : fetch_pc;

    assign push = rd_pending && running && !redirect && !halt;
    assign pop  = instr_valid && instr_ready;

    assign instr_valid = running && (count != 3'd0);
    assign instr       = instr_valid ? buf_data[head] : 16'h0000;
    assign instr_pc    = instr_valid ? buf_pc[head]   : 16'h0000;
    assign halted      = (state == STATE_HALTED);
    assign buf_count   = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STATE_RUN;
            fetch_pc   <= RESET_PC;
            rd_pending <= 1'b0;
            rd_addr    <= RESET_PC;
            head       <= 2'd0;
            tail       <= 2'd0;
            count      <= 3'd0;
        end else begin
            rd_pending <= mem_rd_en;
            if (mem_rd_en) begin
                rd_addr  <= fetch_pc;
                fetch_pc <= fetch_pc + 16'd2;
            end

            if (flush) begin
                // Dropping the pending read also drops the word that arrives
                // this cycle. No read is issued, so nothing else is in flight.
                head  <= 2'd0;
                tail  <= 2'd0;
                count <= 3'd0;
                if (halt) begin
                    state <= STATE_HALTED;
                end else begin
                    fetch_pc <= {redirect_addr[15:1], 1'b0};
                end
            end else if (running) begin
                if (push) begin
                    tail <= tail + 2'd1;
                end
                if (pop) begin
                    head <= head + 2'd1;
                end
                if (push && !pop) begin
                    count <= count + 3'd1;
                end else if (pop && !push) begin
                    count <= count - 3'd1;
                end
            end
        end
    end

    // The storage array has no reset. Entries are only visible when counted.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_data[tail] <= mem_rdata;
            buf_pc[tail]   <= rd_addr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed testbench for fetch_unit. It contains a byte-wide memory model
// that has one cycle of read latency. Expected values are worked out by hand
// from the memory contents.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;
    logic        halted;
    logic [2:0]  buf_count;

    logic [7:0]  mem [65536];
    int          checks;
    int          failures;
    int          rd_count;
    int          rd_snap;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .halted        (halted),
        .buf_count     (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns data one cycle after the strobe. When there is no strobe
    // it returns a junk pattern, so any word that is not dropped shows up.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_rdata <= {mem[mem_addr + 16'd1], mem[mem_addr]};
            rd_count  <= rd_count + 1;
        end else begin
            mem_rdata <= 16'hDEAD;
        end
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {mem[a + 16'd1], mem[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs,
                                input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rd_count      = 0;
        reset         = 1'b1;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        halt          = 1'b0;
        mem_rdata     = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i * 7 + 3);
        end
        mem[0] = 8'h34;
        mem[1] = 8'h12;
        mem[2] = 8'h78;
        mem[3] = 8'h56;

        // Reset state, then streaming with instr_ready held high
        tick();
        tick();
        check_output("rst_rd_en",   16'(mem_rd_en),   16'h0);
        check_output("rst_addr",    mem_addr,         16'h0000);
        check_output("rst_valid",   16'(instr_valid), 16'h0);
        check_output("rst_count",   16'(buf_count),   16'h0);
        check_output("rst_halted",  16'(halted),      16'h0);
        check_output("rst_instr",   instr,            16'h0000);
        check_output("rst_pc",      instr_pc,         16'h0000);
        reset = 1'b0;
        instr_ready = 1'b1;
        #1;
        check_output("c0_rd_en",    16'(mem_rd_en),   16'h1);
        check_output("c0_addr",     mem_addr,         16'h0000);
        check_output("c0_valid",    16'(instr_valid), 16'h0);
        tick();
        check_output("c1_rd_en",    16'(mem_rd_en),   16'h1);
        check_output("c1_addr",     mem_addr,         16'h0002);
        check_output("c1_valid",    16'(instr_valid), 16'h0);
        tick();
        check_output("c2_valid",    16'(instr_valid), 16'h1);
        check_output("c2_instr",    instr,            16'h1234);
        check_output("c2_pc",       instr_pc,         16'h0000);
        check_output("c2_count",    16'(buf_count),   16'h1);
        check_output("c2_addr",     mem_addr,         16'h0004);
        tick();
        check_output("c3_valid",    16'(instr_valid), 16'h1);
        check_output("c3_instr",    instr,            16'h5678);
        check_output("c3_pc",       instr_pc,         16'h0002);
        check_output("c3_count",    16'(buf_count),   16'h1);

        // Back-pressure: the buffer fills and reads stop at 4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr_ready = 1'b0;
        #1;
        rd_snap = rd_count;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr_valid === 1'b1) begin
                check_output("bp_head_stable", instr, 16'h1234);
            end
        end
        check_output("bp_reads",    16'(rd_count - rd_snap), 16'd4);
        check_output("bp_count",    16'(buf_count),   16'h4);
        check_output("bp_rd_en",    16'(mem_rd_en),   16'h0);
        check_output("bp_instr",    instr,            16'h1234);
        check_output("bp_pc",       instr_pc,         16'h0000);
        instr_ready = 1'b1;
        #1;
        check_output("bp_pop_no_rd", 16'(mem_rd_en),  16'h0);
        tick();
        check_output("bp_after_pop_count", 16'(buf_count), 16'h3);
        check_output("bp_after_pop_pc",    instr_pc,       16'h0002);
        check_output("bp_after_pop_rd",    16'(mem_rd_en), 16'h1);
        check_output("bp_after_pop_addr",  mem_addr,       16'h0008);

        // Redirect to an odd address while a read is still in flight
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tick();
        tick();
        check_output("rd_pre_valid", 16'(instr_valid), 16'h1);
        redirect = 1'b1;
        redirect_addr = 16'h0101;
        #1;
        check_output("rd_no_read",   16'(mem_rd_en),   16'h0);
        tick();
        redirect = 1'b0;
        #1;
        check_output("rd_flush_valid", 16'(instr_valid), 16'h0);
        check_output("rd_flush_count", 16'(buf_count),   16'h0);
        check_output("rd_new_rd_en",   16'(mem_rd_en),   16'h1);
        check_output("rd_new_addr",    mem_addr,         16'h0100);
        tick();
        check_output("rd_stale_dropped", 16'(instr_valid), 16'h0);
        check_output("rd_addr2",         mem_addr,         16'h0102);
        tick();
        check_output("rd_first_valid", 16'(instr_valid), 16'h1);
        check_output("rd_first_pc",    instr_pc,         16'h0100);
        check_output("rd_first_instr", instr,            word_at(16'h0100));

        // Fetch address wraps from the top of memory back to zero
        redirect = 1'b1;
        redirect_addr = 16'hFFFE;
        #1;
        check_output("wr_no_read", 16'(mem_rd_en), 16'h0);
        tick();
        redirect = 1'b0;
        #1;
        check_output("wr_addr0",  mem_addr,         16'hFFFE);
        check_output("wr_rd_en0", 16'(mem_rd_en),   16'h1);
        tick();
        check_output("wr_addr1",  mem_addr,         16'h0000);
        tick();
        check_output("wr_addr2",  mem_addr,         16'h0002);
        check_output("wr_valid",  16'(instr_valid), 16'h1);
        check_output("wr_pc",     instr_pc,         16'hFFFE);
        check_output("wr_instr",  instr,            word_at(16'hFFFE));

        // Halt and redirect together: halt wins and fetch stays stopped
        halt = 1'b1;
        redirect = 1'b1;
        redirect_addr = 16'h0200;
        #1;
        check_output("ht_no_read",  16'(mem_rd_en), 16'h0);
        check_output("ht_not_yet",  16'(halted),    16'h0);
        tick();
        halt = 1'b0;
        redirect = 1'b0;
        #1;
        check_output("ht_halted",   16'(halted),      16'h1);
        check_output("ht_valid",    16'(instr_valid), 16'h0);
        check_output("ht_count",    16'(buf_count),   16'h0);
        check_output("ht_rd_en",    16'(mem_rd_en),   16'h0);
        rd_snap = rd_count;
        for (int i = 0; i < 5; i++) begin
            redirect = (i == 2);
            tick();
        end
        redirect = 1'b0;
        #1;
        check_output("ht_no_reads", 16'(rd_count - rd_snap), 16'd0);
        check_output("ht_still",    16'(halted),      16'h1);
        check_output("ht_valid2",   16'(instr_valid), 16'h0);
        check_output("ht_count2",   16'(buf_count),   16'h0);

        // Reset with three entries buffered and one word in flight
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_output("mr_count3", 16'(buf_count), 16'h3);
        reset = 1'b1;
        #1;
        check_output("mr_rd_en_in_reset", 16'(mem_rd_en), 16'h0);
        check_output("mr_addr_in_reset",  mem_addr,        16'h0000);
        tick();
        reset = 1'b0;
        #1;
        check_output("mr_count",  16'(buf_count),   16'h0);
        check_output("mr_valid",  16'(instr_valid), 16'h0);
        check_output("mr_halted", 16'(halted),      16'h0);
        check_output("mr_rd_en",  16'(mem_rd_en),   16'h1);
        check_output("mr_addr",   mem_addr,         16'h0000);
        tick();
        check_output("mr_valid1", 16'(instr_valid), 16'h0);
        check_output("mr_count1", 16'(buf_count),   16'h0);
        tick();
        check_output("mr_valid2", 16'(instr_valid), 16'h1);
        check_output("mr_pc",     instr_pc,         16'h0000);
        check_output("mr_instr",  instr,            16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
